// File: rtl/addr8u_share_ctrl.sv
// addr8u_share_ctrl: round-robin arbiter that shares one 8-bit unsigned adder
// among NREQ requesters and returns a 9-bit sum with valid/ready handshake.
// Optional self-check (operand-swapped recompute) is compiled in with the
// macro ADDR8U_RECHECK_EN; without it out_err and err_cnt are constant 0.
module addr8u_share_ctrl #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] a_in,
    input  logic [8*NREQ-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8:0]        out_sum,
    output logic [2:0]        out_id,
    output logic              out_err,
    output logic [7:0]        err_cnt,
    output logic              busy
);

`ifdef ADDR8U_RECHECK_EN
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, CHECK = 2'd2, RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, RESP = 2'd3} state_t;
`endif

    state_t     state_reg, state_next;
    logic [2:0] ptr_reg;
    logic [2:0] gid_reg;
    logic [2:0] id_reg;
    logic [7:0] op_a_reg, op_b_reg;
    logic [8:0] sum_reg;
    logic       started_reg;   // blocks a grant in the first cycle after reset release

    logic       win_found;
    logic [2:0] win_idx;
    logic       grant_en;
    logic [7:0] sel_a, sel_b;
    logic [7:0] add_x, add_y;
    logic [8:0] add_sum;

`ifdef ADDR8U_RECHECK_EN
    logic       retry_reg;
    logic       err_reg;
    logic [7:0] err_cnt_reg;
`endif

    // Round-robin search: first asserted request at or after the pointer.
    always_comb begin
        int cand;
        cand      = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            for (int k = 0; k < NREQ; k++) begin
                if (!win_found && (k == cand) && req[k]) begin
                    win_found = 1'b1;
                    win_idx   = 3'(k);
                end
            end
        end
    end

    assign grant_en = (state_reg == IDLE) && started_reg && win_found;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt[gi] = grant_en && (win_idx == 3'(gi));
        end
    endgenerate

    // Operand mux selecting the winning requester's slices.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == 3'(k)) begin
                sel_a = a_in[8*k +: 8];
                sel_b = b_in[8*k +: 8];
            end
        end
    end

    // The single shared adder; the self-check feeds it swapped operands.
`ifdef ADDR8U_RECHECK_EN
    assign add_x = (state_reg == CHECK) ? op_b_reg : op_a_reg;
    assign add_y = (state_reg == CHECK) ? op_a_reg : op_b_reg;
`else
    assign add_x = op_a_reg;
    assign add_y = op_b_reg;
`endif
    assign add_sum = {1'b0, add_x} + {1'b0, add_y};

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (grant_en) state_next = CALC;
`ifdef ADDR8U_RECHECK_EN
            CALC: state_next = CHECK;
            CHECK: begin
                if (add_sum == sum_reg) state_next = RESP;
                else if (!retry_reg)    state_next = CHECK;
                else                    state_next = RESP;
            end
`else
            CALC: state_next = RESP;
`endif
            RESP: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, pointer, operand and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= '0;
            gid_reg     <= '0;
            id_reg      <= '0;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            sum_reg     <= '0;
            started_reg <= 1'b0;
`ifdef ADDR8U_RECHECK_EN
            retry_reg   <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            started_reg <= 1'b1;
            if (grant_en) begin
                ptr_reg  <= (win_idx == 3'(NREQ-1)) ? 3'd0 : win_idx + 3'd1;
                gid_reg  <= win_idx;
                op_a_reg <= sel_a;
                op_b_reg <= sel_b;
            end
            if (state_reg == CALC) begin
                sum_reg <= add_sum;
                id_reg  <= gid_reg;
`ifdef ADDR8U_RECHECK_EN
                err_reg   <= 1'b0;
                retry_reg <= 1'b0;
`endif
            end
`ifdef ADDR8U_RECHECK_EN
            if ((state_reg == CHECK) && (add_sum != sum_reg)) begin
                if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
                if (!retry_reg) begin
                    sum_reg   <= add_sum;
                    retry_reg <= 1'b1;
                end else begin
                    err_reg <= 1'b1;
                end
            end
`endif
        end
    end

    assign out_valid = (state_reg == RESP);
    assign busy      = (state_reg != IDLE);
    assign out_sum   = sum_reg;
    assign out_id    = id_reg;
`ifdef ADDR8U_RECHECK_EN
    assign out_err   = err_reg;
    assign err_cnt   = err_cnt_reg;
`else
    assign out_err   = 1'b0;
    assign err_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_addr8u_share_ctrl.sv
// Testbench for addr8u_share_ctrl: directed vector table, fixed sequences for
// arbitration order, stalls and reset abort, plus randomized transactions
// checked against an arithmetic/round-robin reference model.
module tb_addr8u_share_ctrl;
    localparam int NREQ = 4;
`ifdef ADDR8U_RECHECK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif
    localparam int SPACING = LAT + 1;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] a_in;
    logic [8*NREQ-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              out_valid;
    logic              out_ready;
    logic [8:0]        out_sum;
    logic [2:0]        out_id;
    logic              out_err;
    logic [7:0]        err_cnt;
    logic              busy;

    int n_vec = 0;
    int n_bad = 0;

    addr8u_share_ctrl #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_id(out_id), .out_err(out_err),
        .err_cnt(err_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  req;
        logic [31:0] a;
        logic [31:0] b;
        int          hold;
        logic [3:0]  gnt;
        logic [8:0]  sum;
        logic [2:0]  id;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_sum", 32'(out_sum), 0);
        chk("rst_id", 32'(out_id), 0);
        chk("rst_err", 32'(out_err), 0);
        chk("rst_errcnt", 32'(err_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    // Reset, check reset values, and leave one idle cycle so grants are enabled.
    task automatic do_reset();
        rst_n = 1'b0; req = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One request/response transaction, entered at posedge+1 with the DUT idle.
    task automatic run_txn(input logic [3:0] rq, input logic [31:0] a, input logic [31:0] b,
                           input int hold, input logic [3:0] eg, input logic [8:0] es,
                           input logic [2:0] ei, output int waited);
        logic [3:0] got;
        logic [8:0] s0;
        logic [2:0] i0;
        int lat;
        req = rq; a_in = a; b_in = b;
        waited = 0;
        @(negedge clk);
        chk("idle_valid", 32'(out_valid), 0);
        while (gnt == 0 && waited < 20) begin
            @(posedge clk); #1;
            @(negedge clk);
            waited++;
        end
        chk("gnt", 32'(gnt), 32'(eg));
        got = gnt;
        if (got == 0) return;
        lat = 0;
        do begin
            @(posedge clk); #1;
            req = req & ~got;
            @(negedge clk);
            lat++;
            chk("gnt_busy", 32'(gnt), 0);
            chk("busy", 32'(busy), 1);
        end while (!out_valid && lat < 10);
        $display("txn req=%b gnt=%b lat=%0d sum=%h id=%0d", rq, got, lat, out_sum, out_id);
        chk("latency", 32'(lat), 32'(LAT));
        chk("sum", 32'(out_sum), 32'(es));
        chk("id", 32'(out_id), 32'(ei));
        chk("out_err", 32'(out_err), 0);
        s0 = out_sum; i0 = out_id;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_sum", 32'(out_sum), 32'(s0));
            chk("hold_id", 32'(out_id), 32'(i0));
            chk("hold_gnt", 32'(gnt), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int w;
        logic [3:0] gq[$];
        int cq[$];
        logic [2:0] iq[$];
        int ptr_m;
        logic [3:0] pend, rq, eg;
        logic [7:0] ma[4], mb[4];
        logic [31:0] va, vb;
        logic [8:0] es;

        rst_n = 1'b0; req = '0; a_in = '0; b_in = '0; out_ready = 1'b0;

        tbl[0] = '{4'b0001, 32'h0000003C, 32'h00000055, 0, 4'b0001, 9'h091, 3'd0};
        tbl[1] = '{4'b0001, 32'h000000FF, 32'h00000001, 1, 4'b0001, 9'h100, 3'd0};
        tbl[2] = '{4'b0010, 32'h0000FF00, 32'h0000FF00, 0, 4'b0010, 9'h1FE, 3'd1};
        tbl[3] = '{4'b1001, 32'h80000000, 32'h80000000, 2, 4'b1000, 9'h100, 3'd3};
        tbl[4] = '{4'b0111, 32'h00000000, 32'h00000000, 5, 4'b0001, 9'h000, 3'd0};
        tbl[5] = '{4'b0101, 32'h007F0011, 32'h00010022, 0, 4'b0100, 9'h080, 3'd2};
        tbl[6] = '{4'b0011, 32'h0000A00F, 32'h0000700E, 1, 4'b0001, 9'h01D, 3'd0};

        // Directed table, pointer starts at 0 after reset.
        do_reset();
        for (int v = 0; v < 7; v++) begin
            run_txn(tbl[v].req, tbl[v].a, tbl[v].b, tbl[v].hold, tbl[v].gnt,
                    tbl[v].sum, tbl[v].id, w);
            chk("tbl_wait", 32'(w), 0);
        end

        // All four requesting with out_ready held high: rotation order and spacing.
        do_reset();
        req = 4'b1111; a_in = 32'h44332211; b_in = 32'h01010101; out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (gnt != 0) begin gq.push_back(gnt); cq.push_back(c); end
            if (out_valid) iq.push_back(out_id);
            @(posedge clk); #1;
        end
        req = '0; out_ready = 1'b0;
        chk("rr_count", 32'(gq.size() >= 5), 1);
        if (gq.size() >= 5) begin
            for (int j = 0; j < 5; j++) begin
                $display("rr grant %0d gnt=%b cycle=%0d", j, gq[j], cq[j]);
                chk("rr_order", 32'(gq[j]), 32'(4'b0001 << (j % 4)));
            end
            for (int j = 0; j < 4; j++) chk("rr_spacing", 32'(cq[j+1] - cq[j]), 32'(SPACING));
        end
        chk("rr_idcount", 32'(iq.size() >= 4), 1);
        if (iq.size() >= 4)
            for (int j = 0; j < 4; j++) chk("rr_id", 32'(iq[j]), 32'(j));

        // Reset during CALC aborts; regrant waits one cycle after release.
        do_reset();
        req = 4'b0001; a_in = 32'h00000077; b_in = 32'h00000011;
        w = 0;
        @(negedge clk);
        while (gnt == 0 && w < 10) begin @(posedge clk); #1; @(negedge clk); w++; end
        chk("abort_gnt", 32'(gnt), 32'(4'b0001));
        @(posedge clk); #1;
        rst_n = 1'b0; req = '0;
        @(posedge clk); #1;
        @(negedge clk);
        $display("abort reset state valid=%b busy=%b sum=%h", out_valid, busy, out_sum);
        check_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn(4'b0100, 32'h00120000, 32'h00340000, 0, 4'b0100, 9'h046, 3'd2, w);
        chk("rel_wait", 32'(w), 1);

        // Randomized transactions against the reference model.
        do_reset();
        ptr_m = 0; pend = '0;
        for (int k = 0; k < 4; k++) begin ma[k] = '0; mb[k] = '0; end
        for (int t = 0; t < 40; t++) begin
            rq = pend | 4'($urandom_range(0, 15));
            if (rq == 0) rq[$urandom_range(0, 3)] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (rq[k] && !pend[k]) begin
                    ma[k] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
                    mb[k] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
                end
            end
            w = -1;
            for (int i = 0; i < 4; i++)
                if (w < 0 && rq[(ptr_m + i) % 4]) w = (ptr_m + i) % 4;
            eg = '0; eg[w] = 1'b1;
            es = 9'(int'(ma[w]) + int'(mb[w]));
            for (int k = 0; k < 4; k++) begin va[8*k +: 8] = ma[k]; vb[8*k +: 8] = mb[k]; end
            run_txn(rq, va, vb, $urandom_range(0, 3), eg, es, 3'(w), w);
            chk("rand_wait", 32'(w), 0);
            ptr_m = (ptr_m + 0 == ptr_m) ? 0 : 0;
            for (int i = 0; i < 4; i++) if (eg[i]) ptr_m = (i + 1) % 4;
            pend = rq & ~eg;
        end
        chk("errcnt_clean", 32'(err_cnt), 0);

`ifdef ADDR8U_RECHECK_EN
        // Adder fault on sum bit 3 during CALC and second CHECK: both checks miss.
        do_reset();
        req = 4'b0001; a_in = 32'h0000003C; b_in = 32'h00000055;
        w = 0;
        @(negedge clk);
        while (gnt == 0 && w < 10) begin @(posedge clk); #1; @(negedge clk); w++; end
        chk("flt_gnt", 32'(gnt), 32'(4'b0001));
        force dut.add_sum = 9'h099;
        @(posedge clk); #1; req = '0;
        @(posedge clk); #1; release dut.add_sum;
        @(posedge clk); #1; force dut.add_sum = 9'h099;
        @(negedge clk);
        chk("flt_valid_t3", 32'(out_valid), 0);
        @(posedge clk); #1; release dut.add_sum;
        @(negedge clk);
        $display("fault valid=%b err=%b errcnt=%0d sum=%h", out_valid, out_err, err_cnt, out_sum);
        chk("flt_valid_t4", 32'(out_valid), 1);
        chk("flt_errcnt", 32'(err_cnt), 2);
        chk("flt_err", 32'(out_err), 1);
        chk("flt_sum", 32'(out_sum), 32'h091);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
